// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter.
// Open-drain ps2c/ps2d; the receive path must ignore the bus while tx_idle is low.
`timescale 1ns/1ps
module ps2_tx #(
   parameter int RTS_CYCLES     = 12000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2d,
   inout  wire        ps2c,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       tx_err
);

   localparam int CMAX = (RTS_CYCLES > TIMEOUT_CYCLES) ?
                         RTS_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);
   localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RTS,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_t;

   state_t                state;
   logic [FILTER_LEN-1:0] filt;
   logic [FILTER_LEN-1:0] filt_next;
   logic                  f_ps2c;
   logic                  f_next;
   logic                  fall_edge;
   logic [1:0]            d_sync;
   logic [8:0]            sh;
   logic [3:0]            n;
   logic [CW-1:0]         cnt;
   logic                  c_oe;
   logic                  d_oe;
   logic                  active;
   logic                  line_ok;
   logic                  timeout;

   assign ps2c = c_oe ? 1'b0 : 1'bz;
   assign ps2d = d_oe ? 1'b0 : 1'bz;

   assign filt_next = {ps2c, filt[FILTER_LEN-1:1]};

   always_comb begin
      f_next = f_ps2c;
      if (&filt_next)
         f_next = 1'b1;
      else if (~|filt_next)
         f_next = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt      <= '0;
         f_ps2c    <= 1'b0;
         fall_edge <= 1'b0;
         d_sync    <= '0;
      end else begin
         filt      <= filt_next;
         f_ps2c    <= f_next;
         fall_edge <= f_ps2c & ~f_next;
         d_sync    <= {d_sync[0], ps2d};
      end
   end

   // A fall_edge in the same clk as an expiring count counts as progress.
   always_comb begin
      active  = (state == S_START) || (state == S_DATA) ||
                (state == S_STOP)  || (state == S_WAIT);
      line_ok = f_ps2c & d_sync[1];
      timeout = active & ~fall_edge & (cnt == '0) &
                ~((state == S_WAIT) & line_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         c_oe         <= 1'b0;
         d_oe         <= 1'b0;
         tx_idle      <= 1'b1;
         tx_done_tick <= 1'b0;
         tx_err       <= 1'b0;
         sh           <= '0;
         n            <= '0;
         cnt          <= '0;
      end else begin
         tx_done_tick <= 1'b0;
         if (active)
            cnt <= fall_edge ? TO_LOAD : cnt - CW'(1);
         if (timeout) begin
            c_oe         <= 1'b0;
            d_oe         <= 1'b0;
            tx_err       <= 1'b1;
            tx_done_tick <= 1'b1;
            tx_idle      <= 1'b1;
            state        <= S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (wr_ps2) begin
                     sh      <= {~^din, din};
                     tx_err  <= 1'b0;
                     cnt     <= RTS_LOAD;
                     c_oe    <= 1'b1;
                     tx_idle <= 1'b0;
                     state   <= S_RTS;
                  end
               end
               S_RTS: begin
                  if (cnt == '0) begin
                     c_oe  <= 1'b0;
                     d_oe  <= 1'b1;
                     cnt   <= TO_LOAD;
                     state <= S_START;
                  end else begin
                     cnt <= cnt - CW'(1);
                     // start bit goes low one clk before ps2c is released
                     if (cnt == CW'(1))
                        d_oe <= 1'b1;
                  end
               end
               S_START: begin
                  if (fall_edge) begin
                     d_oe  <= ~sh[0];
                     n     <= 4'd8;
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (fall_edge) begin
                     if (n == 4'd0) begin
                        d_oe  <= 1'b0;
                        state <= S_STOP;
                     end else begin
                        sh   <= {1'b0, sh[8:1]};
                        d_oe <= ~sh[1];
                        n    <= n - 4'd1;
                     end
                  end
               end
               S_STOP: begin
                  if (fall_edge) begin
                     tx_err <= d_sync[1];
                     state  <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (line_ok) begin
                     tx_done_tick <= 1'b1;
                     tx_idle      <= 1'b1;
                     state        <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: PS/2 device model clocks frames out of ps2_tx and
// checks bits, ACK status, RTS timing, timeout and reset against a reference.
`timescale 1ns/1ps
module tb_ps2_tx;

   localparam int RTS  = 40;
   localparam int FLEN = 8;
   localparam int TOUT = 400;
   localparam int HALF = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_ps2;
   logic [7:0] din;
   wire        ps2c_w;
   wire        ps2d_w;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err;

   logic dev_c_oe;
   logic dev_d_oe;
   bit   dev_abort;
   bit   exp_busy;
   bit   exp_err;
   int   tests;
   int   fails;
   int   cyc;

   pullup (ps2c_w);
   pullup (ps2d_w);
   assign ps2c_w = dev_c_oe ? 1'b0 : 1'bz;
   assign ps2d_w = dev_d_oe ? 1'b0 : 1'bz;

   ps2_tx #(
      .RTS_CYCLES(RTS),
      .FILTER_LEN(FLEN),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wr_ps2(wr_ps2),
      .din(din),
      .ps2d(ps2d_w),
      .ps2c(ps2c_w),
      .tx_idle(tx_idle),
      .tx_done_tick(tx_done_tick),
      .tx_err(tx_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Frame as seen on successive device clocks: start, LSB-first data,
   // odd parity, stop; bit k of the result is the k-th bit on the wire.
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
      logic par;
      par = ($countones(d) % 2) == 0;
      return {1'b1, par, d, 1'b0};
   endfunction

   // Per-cycle compare against the transaction-level busy/err model.
   always @(negedge clk) begin
      if (!reset) begin
         if (tx_done_tick) begin
            chk("done_expected", exp_busy, 1);
            chk("err_at_done", tx_err, exp_err);
            exp_busy = 0;
         end
         chk("tx_idle", tx_idle, !exp_busy);
         if (!exp_busy) begin
            chk("err_hold", tx_err, exp_err);
            chk("c_released", ps2c_w | dev_c_oe, 1);
            chk("d_released", ps2d_w | dev_d_oe, 1);
         end
      end
   end

   task automatic do_write(input logic [7:0] d, input bit err_exp);
      @(negedge clk);
      din    = d;
      wr_ps2 = 1'b1;
      @(posedge clk);
      #1;
      wr_ps2 = 1'b0;
      if (!exp_busy && !reset) begin
         exp_busy = 1;
         exp_err  = err_exp;
      end
   endtask

   task automatic dev_frame(input bit ack, input int glitch_k,
                            input int glitch_w,
                            output logic [10:0] bits, output bit ok);
      int t;
      ok   = 0;
      bits = '0;
      t    = 0;
      while (ps2c_w !== 1'b0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      t = 0;
      while (ps2c_w !== 1'b1 && t < RTS + 10) begin
         @(negedge clk);
         t++;
      end
      if (ps2c_w !== 1'b1) begin
         chk("dev_rts_release", ps2c_w, 1);
         return;
      end
      for (int k = 0; k < 11; k++) begin
         repeat (3) @(negedge clk);
         if (k == glitch_k) begin
            dev_c_oe = 1'b1;
            repeat (glitch_w) @(negedge clk);
            dev_c_oe = 1'b0;
         end
         repeat (HALF / 2 - 3) @(negedge clk);
         if (dev_abort) return;
         bits[k] = ps2d_w;
         if (k == 10 && ack) dev_d_oe = 1'b1;
         repeat (HALF / 2) @(negedge clk);
         if (dev_abort) return;
         dev_c_oe = 1'b1;
         repeat (HALF) @(negedge clk);
         if (dev_abort) return;
         dev_c_oe = 1'b0;
         dev_d_oe = 1'b0;
      end
      ok = 1;
   endtask

   task automatic wait_done(input string nm);
      int t;
      t = 0;
      while (exp_busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk(nm, exp_busy, 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic run_frame(input string nm, input logic [7:0] d,
                            input bit ack, input int gk, input int gw,
                            output logic [10:0] bits);
      bit ok;
      do_write(d, !ack);
      dev_frame(ack, gk, gw, bits, ok);
      chk({nm, "_dev_ok"}, ok, 1);
      chk({nm, "_frame"}, bits, exp_frame(d));
      wait_done({nm, "_done"});
   endtask

   initial begin
      logic [10:0] bits;
      bit          ok;
      int          n_low;
      int          t;
      int          t_rel;
      logic        last_d;
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      dev_c_oe  = 1'b0;
      dev_d_oe  = 1'b0;
      dev_abort = 0;
      exp_busy  = 0;
      exp_err   = 0;
      wr_ps2    = 1'b0;
      din       = '0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_idle", tx_idle, 1);
      chk("rst_done", tx_done_tick, 0);
      chk("rst_err", tx_err, 0);
      chk("rst_c", ps2c_w, 1);
      chk("rst_d", ps2d_w, 1);
      reset = 1'b0;
      repeat (12) @(negedge clk);

      run_frame("f4", 8'hF4, 1, -1, 0, bits);
      chk("f4_literal", bits, 11'b10111101000);
      run_frame("x00", 8'h00, 1, -1, 0, bits);
      chk("x00_parity", bits[9], 1);
      run_frame("xff", 8'hFF, 1, -1, 0, bits);
      chk("xff_parity", bits[9], 1);
      run_frame("nack", 8'h12, 0, -1, 0, bits);

      // No device clocking: RTS timing, then timeout abort.
      do_write(8'h55, 1);
      @(negedge clk);
      chk("rts_first_low", ps2c_w, 0);
      n_low  = 0;
      last_d = 1'b1;
      while (ps2c_w === 1'b0 && n_low < RTS + 20) begin
         n_low++;
         last_d = ps2d_w;
         @(negedge clk);
      end
      chk("rts_len", n_low, RTS);
      chk("d_low_before_release", last_d, 0);
      t_rel = cyc;
      t     = 0;
      while (!tx_done_tick && t < TOUT + 50) begin
         @(negedge clk);
         t++;
      end
      chk("timeout_cycles", cyc - t_rel, TOUT);
      chk("timeout_c_z", ps2c_w, 1);
      chk("timeout_d_z", ps2d_w, 1);
      chk("timeout_err", tx_err, 1);
      wait_done("timeout_done");

      // Second write mid-frame is ignored.
      do_write(8'h5A, 0);
      fork
         dev_frame(1, -1, 0, bits, ok);
         begin
            repeat (RTS + 150) @(negedge clk);
            do_write(8'h3C, 0);
         end
      join
      chk("busy_frame", bits, exp_frame(8'h5A));
      wait_done("busy_done");

      // Reset in the middle of the data bits.
      do_write(8'hC3, 0);
      fork
         dev_frame(1, -1, 0, bits, ok);
         begin
            repeat (RTS + 200) @(negedge clk);
            #3;
            reset     = 1'b1;
            dev_abort = 1;
            dev_c_oe  = 1'b0;
            dev_d_oe  = 1'b0;
            exp_busy  = 0;
            exp_err   = 0;
            #1;
            chk("mid_rst_c", ps2c_w, 1);
            chk("mid_rst_d", ps2d_w, 1);
            chk("mid_rst_idle", tx_idle, 1);
         end
      join
      repeat (3) @(negedge clk);
      reset     = 1'b0;
      dev_abort = 0;
      repeat (12) @(negedge clk);
      run_frame("after_rst", 8'hA5, 1, -1, 0, bits);

      // Reset and wr_ps2 together: reset wins.
      @(negedge clk);
      reset  = 1'b1;
      din    = 8'h77;
      wr_ps2 = 1'b1;
      @(posedge clk);
      #1;
      wr_ps2 = 1'b0;
      @(negedge clk);
      chk("rst_wr_idle", tx_idle, 1);
      chk("rst_wr_c", ps2c_w, 1);
      reset = 1'b0;
      repeat (12) @(negedge clk);

      // Randomized frames; odd iterations inject short ps2c glitches.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         bit         ack;
         int         gk;
         int         gw;
         d   = 8'($urandom);
         ack = $urandom_range(0, 3) != 0;
         gk  = (i % 2 == 1) ? int'($urandom_range(2, 8)) : -1;
         gw  = int'($urandom_range(1, FLEN - 1));
         run_frame($sformatf("rnd%0d", i), d, ack, gk, gw, bits);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
      $fatal(1);
   end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") from the FPGA to the mouse over the shared ps2c/ps2d lines. It sits beside the existing PS/2 receive path. The receiver must ignore the bus while tx_idle is low.

Parameters:
RTS_CYCLES, 12000, clock cycles ps2c is held low for request-to-send (at least 100 us at the system clock).
FILTER_LEN, 8, depth of the ps2c glitch-filter shift register.
TIMEOUT_CYCLES, 2000000, maximum cycles allowed between consecutive device clock falling edges before the frame is aborted.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous reset, active-high.
wr_ps2  in  1  one-cycle strobe; starts a transmission of din when the block is idle.
din  in  8  byte to send.
ps2d  inout  1  PS/2 data line; open-drain (drives 0 or Z, never 1).
ps2c  inout  1  PS/2 clock line; open-drain.
tx_idle  out  1  high when no frame is in progress.
tx_done_tick  out  1  one-cycle pulse at the end of a frame, whether it succeeded or aborted.
tx_err  out  1  status of the last frame: 1 = no ACK or timeout. Valid from tx_done_tick until the next wr_ps2 is accepted.

Behaviour:
- Reset (async, active-high):
  - State = idle; both lines released (Z).
  - tx_idle=1, tx_done_tick=0, tx_err=0; shift register and counters cleared.
  - Reset mid-frame releases both lines immediately.
- Clock filter:
  - The FILTER_LEN shift register samples ps2c every clk.
  - f_ps2c goes to 1 when all taps are 1 and to 0 when all taps are 0; otherwise it holds its value.
  - fall_edge = f_ps2c transitioning 1->0. It is registered, one clk wide.
- Frame register at wr_ps2 acceptance: {par, din} with par = ~^din (odd parity).
- FSM:
  - idle: tx_idle=1. When wr_ps2=1, load the frame, clear tx_err, load the counter with RTS_CYCLES-1, go to rts. wr_ps2 is ignored in every other state.
  - rts: drive ps2c=0. On counter==0, go to start.
  - start: release ps2c, drive ps2d=0 (start bit). On fall_edge, present bit 0, set n=8, go to data.
  - data: ps2d = released if the current bit is 1, driven 0 if it is 0. On each fall_edge, shift right. Bits go out LSB first, then parity. After the parity bit's fall_edge (n=0), go to stop.
  - stop: release ps2d (stop bit = 1). On fall_edge, sample filtered ps2d: 0 = ACK, tx_err=0; 1 = tx_err=1. Go to wait_idle.
  - wait_idle: wait until f_ps2c=1 and ps2d=1, then pulse tx_done_tick and go to idle.
- Timeout:
  - The counter is reloaded at each fall_edge and on entry to start.
  - In start, data, stop or wait_idle, if TIMEOUT_CYCLES elapse without progress: release both lines, tx_err=1, pulse tx_done_tick, go to idle.
- Bit timing:
  - ps2d changes only in the clk after a detected fall_edge; it is stable while the device clock is high.
- Latency: ps2c goes low 1 clk after wr_ps2 and stays low exactly RTS_CYCLES clks.
- Simultaneous events: if reset and wr_ps2 occur together, reset wins. If a timeout and a fall_edge occur in the same clk, the fall_edge wins.
- Lines are never driven to 1.

Test Plan:
- wr_ps2 with din=0xF4, with a device model clocking at 12.5 kHz and ACKing:
  - bits on successive fall_edges: 0 (start), 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - then tx_done_tick once, tx_err=0, tx_idle back to 1.
- din=0x00 and din=0xFF -> parity bit = 1 in both cases; both bytes received correctly by the model.
- RTS check -> ps2c low for exactly RTS_CYCLES clks starting 1 clk after wr_ps2; ps2d=0 before ps2c is released.
- Device model holds ps2d high at the ACK clock -> tx_done_tick with tx_err=1.
- Device never clocks after RTS -> after TIMEOUT_CYCLES: both lines Z, tx_err=1, single tx_done_tick.
- Busy and reset cases:
  - a second wr_ps2 during the data state is ignored, and the frame completes unchanged;
  - asserting reset in the middle of the data state releases both lines asynchronously, and the next wr_ps2 sends a full fresh frame;
  - 1-clk glitches on ps2c shorter than FILTER_LEN produce no bit advance.
